div34_serial_framer: RTL

Serial front-end for the divisible-by-3-or-4 detector. It takes a gated bit stream, MSB first, and assembles it into 4-bit frames A,B,C,D. While the bits arrive, a remainder state machine tracks the value so that a registered divisibility flag is ready on the same cycle as the frame. Its A,B,C,D outputs drive the combinational detector directly downstream; its `div` output is the reference value that detector's output is checked against.

---
 rtl/div34_serial_framer.sv | 97 +++++++++
 1 files changed

// File: rtl/div34_serial_framer.sv
// div34_serial_framer: assembles an MSB-first serial stream into 4-bit frames A..D with a registered
// divisible-by-3-or-4 flag. The divisible-frame hit counter is built only when DIV34_HITCNT_EN is defined.
module div34_serial_framer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             frame_clr,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    output logic             nib_vld,
    output logic             div,
    output logic [CNT_W-1:0] hit_cnt
);
    typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2} rem_t;

    rem_t       rem3;
    rem_t       rem3_nxt;
    rem_t       rem_step;
    logic [1:0] pos;
    // The fourth bit is never stored: it is consumed directly on the completing edge.
    logic [2:0] sr;
    logic       accept;
    logic       done;
    logic       div_new;

    assign accept  = bit_vld & ~frame_clr;
    assign done    = accept & (pos == 2'd3);
    assign div_new = (rem_step == R0) | (~sr[0] & ~bit_in);

    always_comb begin
        rem_step = R0;
        case (rem3)
            R0:      rem_step = bit_in ? R1 : R0;
            R1:      rem_step = bit_in ? R0 : R2;
            R2:      rem_step = bit_in ? R2 : R1;
            default: rem_step = R0;
        endcase
    end

    always_comb begin
        rem3_nxt = rem3;
        if (frame_clr)
            rem3_nxt = R0;
        else if (bit_vld)
            rem3_nxt = (pos == 2'd3) ? R0 : rem_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem3 <= R0;
        else
            rem3 <= rem3_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= 2'd0;
            sr      <= 3'd0;
            A       <= 1'b0;
            B       <= 1'b0;
            C       <= 1'b0;
            D       <= 1'b0;
            div     <= 1'b0;
            nib_vld <= 1'b0;
        end else begin
            nib_vld <= done;
            if (frame_clr || done) begin
                pos <= 2'd0;
                sr  <= 3'd0;
            end else if (accept) begin
                pos <= pos + 2'd1;
                sr  <= {sr[1:0], bit_in};
            end
            if (done) begin
                {A, B, C, D} <= {sr, bit_in};
                div          <= div_new;
            end
        end
    end

`ifdef DIV34_HITCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit_cnt <= '0;
        else if (done && div_new && (hit_cnt != {CNT_W{1'b1}}))
            hit_cnt <= hit_cnt + CNT_W'(1);
    end
`else
    assign hit_cnt = '0;
`endif

endmodule
